// File: rtl/spi_flash_pkg.sv
// ============================================================================
// Module      : spi_flash_pkg
// Description : Opcodes, FSM encoding and default status byte for the SPI
//               flash emulator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_STAT  = 8'hD7;

  localparam logic [7:0] STATUS_DEFAULT = 8'hB4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_STAT   = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_pin_sync.sv
// ============================================================================
// Module      : spi_pin_sync
// Description : Two-flop pin synchroniser with optional registered edge pulses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_pin_sync #(
  parameter bit EDGE_DET = 1'b1,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic PIN,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  logic [1:0] r_sync;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], PIN};
    end
  end

  assign LEVEL = r_sync[1];

  generate
    if (EDGE_DET) begin : g_edge
      logic r_last;
      logic r_rise;
      logic r_fall;

      // Edge pulses are registered so downstream logic sees a clean one-cycle strobe.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          r_last <= RST_VAL;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_last <= r_sync[1];
          r_rise <= r_sync[1] & ~r_last;
          r_fall <= ~r_sync[1] & r_last;
        end
      end

      assign RISE = r_rise;
      assign FALL = r_fall;
    end else begin : g_no_edge
      assign RISE = 1'b0;
      assign FALL = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_flash_emu.sv
// ============================================================================
// Module      : spi_flash_emu
// Description : Oversampled SPI flash emulator (read, fast read, status read).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_flash_emu
  import spi_flash_pkg::*;
#(
  parameter int         DSZ       = 16,
  parameter int         ASZ       = 24,
  parameter int         IDX_W     = 12,
  parameter int         BYTE_BITS = 9,
  parameter int         PG_LSB    = 10,
  parameter logic [7:0] STATUS    = STATUS_DEFAULT
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CS,
  input  logic             SCK,
  input  logic             SI,
  output logic             SO,
  output logic             ACTIVE,
  input  logic             LD_EN,
  input  logic [IDX_W-1:0] LD_ADDR,
  input  logic [DSZ-1:0]   LD_DATA
);

  localparam int c_CNT_MAX = (ASZ > DSZ) ? ASZ : DSZ;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_si;
  logic w_sck_lvl_unused, w_cs_lvl_unused, w_si_rise_unused, w_si_fall_unused;

  spi_pin_sync #(.EDGE_DET(1'b1), .RST_VAL(1'b0)) u_sck_sync (
    .CLK(CLK), .RSTN(RSTN), .PIN(SCK),
    .LEVEL(w_sck_lvl_unused), .RISE(w_sck_rise), .FALL(w_sck_fall)
  );

  spi_pin_sync #(.EDGE_DET(1'b1), .RST_VAL(1'b1)) u_cs_sync (
    .CLK(CLK), .RSTN(RSTN), .PIN(CS),
    .LEVEL(w_cs_lvl_unused), .RISE(w_cs_rise), .FALL(w_cs_fall)
  );

  spi_pin_sync #(.EDGE_DET(1'b0), .RST_VAL(1'b0)) u_si_sync (
    .CLK(CLK), .RSTN(RSTN), .PIN(SI),
    .LEVEL(w_si), .RISE(w_si_rise_unused), .FALL(w_si_fall_unused)
  );

  state_t             r_state;
  logic               r_dummy;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic [ASZ-2:0]     r_shift_in;
  logic [DSZ-1:0]     r_shift_out;
  logic [IDX_W-1:0]   r_rd_idx;
  logic [DSZ-1:0]     r_mem_q;
  logic               r_so;
  logic               r_active;

  logic [DSZ-1:0]     r_mem [2**IDX_W];

  logic [7:0]         w_cmd;
  logic [ASZ-1:0]     w_addr;
  logic [IDX_W-1:0]   w_idx;
  logic [DSZ-1:0]     w_word;
  logic               w_addr_unused;

  assign w_cmd  = {r_shift_in[6:0], w_si};
  assign w_addr = {r_shift_in, w_si};
  // Byte LSB dropped (two bytes per word); bits above the page field ignored.
  assign w_idx  = {w_addr[PG_LSB +: IDX_W-BYTE_BITS+1], w_addr[BYTE_BITS-1:1]};
  assign w_addr_unused = ^w_addr;
  assign w_word = (r_bit_cnt == '0) ? r_mem_q : r_shift_out;

  always_ff @(posedge CLK) begin
    if (LD_EN && (r_state == ST_IDLE)) begin
      r_mem[LD_ADDR] <= LD_DATA;
    end
    r_mem_q <= r_mem[r_rd_idx];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= ST_IDLE;
      r_dummy     <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_rd_idx    <= '0;
      r_so        <= 1'b0;
      r_active    <= 1'b0;
    end else if (w_cs_rise) begin
      // Deselect overrides any SCK edge detected in the same cycle.
      r_state   <= ST_IDLE;
      r_so      <= 1'b0;
      r_active  <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= ST_CMD;
            r_bit_cnt <= '0;
            r_active  <= 1'b1;
            r_so      <= 1'b0;
          end
        end
        ST_CMD: begin
          if (w_sck_rise) begin
            r_shift_in <= {r_shift_in[ASZ-3:0], w_si};
            if (r_bit_cnt == c_CNT_W'(7)) begin
              r_bit_cnt <= '0;
              case (w_cmd)
                OP_READ:  begin r_state <= ST_ADDR; r_dummy <= 1'b0; end
                OP_FREAD: begin r_state <= ST_ADDR; r_dummy <= 1'b1; end
                OP_STAT:  r_state <= ST_STAT;
                default:  r_state <= ST_IGNORE;
              endcase
            end else begin
              r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_ADDR: begin
          if (w_sck_rise) begin
            r_shift_in <= {r_shift_in[ASZ-3:0], w_si};
            if (r_bit_cnt == c_CNT_W'(ASZ-1)) begin
              r_bit_cnt <= '0;
              r_rd_idx  <= w_idx;
              r_state   <= r_dummy ? ST_DUMMY : ST_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_DUMMY: begin
          if (w_sck_rise) begin
            if (r_bit_cnt == c_CNT_W'(7)) begin
              r_bit_cnt <= '0;
              r_state   <= ST_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (w_sck_fall) begin
            r_so        <= w_word[DSZ-1];
            r_shift_out <= {w_word[DSZ-2:0], 1'b0};
            if (r_bit_cnt == c_CNT_W'(DSZ-1)) begin
              r_bit_cnt <= '0;
              r_rd_idx  <= r_rd_idx + IDX_W'(1);
            end else begin
              r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_STAT: begin
          if (w_sck_fall) begin
            r_so      <= STATUS[3'd7 - r_bit_cnt[2:0]];
            r_bit_cnt <= (r_bit_cnt == c_CNT_W'(7)) ? '0 : r_bit_cnt + c_CNT_W'(1);
          end
        end
        ST_IGNORE: begin
          r_so <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign SO     = r_so;
  assign ACTIVE = r_active;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_emu.sv
// ============================================================================
// Module      : tb_spi_flash_emu
// Description : Randomised SPI master with behavioural flash model and
//               cycle-by-cycle SO/ACTIVE comparison.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_flash_emu;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        CS = 1'b1;
  logic        SCK = 1'b0;
  logic        SI = 1'b0;
  logic        LD_EN = 1'b0;
  logic [11:0] LD_ADDR = '0;
  logic [15:0] LD_DATA = '0;
  logic        SO;
  logic        ACTIVE;

  always #5 CLK = ~CLK;

  spi_flash_emu dut (
    .CLK(CLK), .RSTN(RSTN), .CS(CS), .SCK(SCK), .SI(SI),
    .SO(SO), .ACTIVE(ACTIVE),
    .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
  );

  typedef struct {
    int   cyc;
    logic so;
    logic act;
  } ev_t;

  ev_t         evq[$];
  int          negcnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        exp_so = 1'b0;
  logic        exp_act = 1'b0;
  bit          en = 1'b0;
  logic [15:0] model_mem [4096];
  logic        rx [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pin state follows the master's pin activity by exactly four CLK.
  always @(negedge CLK) begin
    negcnt++;
    while (evq.size() > 0 && evq[0].cyc <= negcnt) begin
      exp_so  = evq[0].so;
      exp_act = evq[0].act;
      evq.delete(0);
    end
    if (en) begin
      chk("so", SO, exp_so);
      chk("active", ACTIVE, exp_act);
    end
  end

  function automatic int map_idx(input logic [23:0] addr);
    return ((int'(addr) >> 10) & 'hF) * 256 + ((int'(addr) >> 1) & 'hFF);
  endfunction

  // SO value the master sees after SCK fall number i of a transaction.
  function automatic logic exp_bit(input logic [7:0] op, input logic [23:0] addr, input int i);
    int          pre;
    int          k;
    int          idx;
    logic [15:0] w;
    logic [7:0]  st;
    st = 8'hB4;
    case (op)
      8'h03:   pre = 32;
      8'h0B:   pre = 40;
      8'hD7:   pre = 8;
      default: return 1'b0;
    endcase
    if (i < pre - 1) return 1'b0;
    k = i - (pre - 1);
    if (op == 8'hD7) return st[7 - (k % 8)];
    idx = (map_idx(addr) + k / 16) % 4096;
    w = model_mem[idx];
    return w[15 - (k % 16)];
  endfunction

  function automatic logic [15:0] getword(input int start);
    logic [15:0] w;
    for (int b = 0; b < 16; b++) w[15-b] = rx[start+b];
    return w;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic push_ev(input logic so, input logic act);
    ev_t e;
    e.cyc = negcnt + 4;
    e.so  = so;
    e.act = act;
    evq.push_back(e);
  endtask

  task automatic idle_load(input logic [11:0] idx, input logic [15:0] d);
    LD_ADDR = idx;
    LD_DATA = d;
    LD_EN   = 1'b1;
    wait_clk(1);
    LD_EN   = 1'b0;
    model_mem[idx] = d;
    wait_clk(2);
  endtask

  task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int nclk,
                      input bit simul, input int rst_at, input int ld_at,
                      input logic [11:0] ld_idx, input logic [15:0] ld_data);
    logic si_bits [0:255];
    for (int i = 0; i < 256; i++) begin
      rx[i] = 1'b0;
      si_bits[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++)  si_bits[i] = op[7-i];
    for (int i = 0; i < 24; i++) si_bits[8+i] = addr[23-i];
    if (op == 8'h0B) for (int i = 32; i < 40; i++) si_bits[i] = 1'b1;
    CS = 1'b0;
    push_ev(1'b0, 1'b1);
    wait_clk(6);
    for (int i = 0; i < nclk; i++) begin
      SI = si_bits[i];
      wait_clk(6);
      if (i > 0) rx[i-1] = SO;
      SCK = 1'b1;
      if (i == ld_at) begin
        LD_ADDR = ld_idx;
        LD_DATA = ld_data;
        LD_EN   = 1'b1;
        wait_clk(1);
        LD_EN   = 1'b0;
        wait_clk(5);
      end else begin
        wait_clk(6);
      end
      SCK = 1'b0;
      push_ev(exp_bit(op, addr, i), 1'b1);
      if (simul && i == nclk - 1) begin
        CS = 1'b1;
        push_ev(1'b0, 1'b0);
        wait_clk(10);
        return;
      end
      if (i == rst_at) begin
        #2;
        RSTN = 1'b0;
        #1;
        chk("rst_so", SO, 0);
        chk("rst_active", ACTIVE, 0);
        evq.delete();
        exp_so  = 1'b0;
        exp_act = 1'b0;
        CS = 1'b1;
        wait_clk(4);
        RSTN = 1'b1;
        wait_clk(10);
        return;
      end
    end
    wait_clk(6);
    rx[nclk-1] = SO;
    CS = 1'b1;
    push_ev(1'b0, 1'b0);
    wait_clk(10);
  endtask

  initial begin
    logic [15:0] w;
    logic        acc;
    logic [7:0]  op;
    int          sel;

    chk("map_901", map_idx(24'h002402), 32'h901);
    chk("map_fff", map_idx(24'h003DFE), 32'hFFF);

    wait_clk(3);
    chk("reset_so", SO, 0);
    chk("reset_active", ACTIVE, 0);
    RSTN = 1'b1;
    wait_clk(3);
    en = 1'b1;

    for (int i = 0; i < 4096; i++) begin
      LD_ADDR = 12'(i);
      LD_DATA = 16'(i << 4);
      LD_EN   = 1'b1;
      model_mem[i] = 16'(i << 4);
      wait_clk(1);
    end
    LD_EN = 1'b0;
    wait_clk(4);

    xfer(8'h03, 24'h002402, 80, 1'b0, -1, -1, 12'h0, 16'h0);
    chk("ramp_w0", getword(31), 32'h9010);
    chk("ramp_w1", getword(47), 32'h9020);
    chk("ramp_w2", getword(63), 32'h9030);

    xfer(8'h0B, 24'h002402, 72, 1'b0, -1, -1, 12'h0, 16'h0);
    acc = 1'b0;
    for (int i = 31; i < 39; i++) acc = acc | rx[i];
    chk("fread_dummy_zero", acc, 0);
    chk("fread_w0", getword(39), 32'h9010);
    chk("fread_w1", getword(55), 32'h9020);

    xfer(8'h03, 24'h003DFE, 80, 1'b0, -1, -1, 12'h0, 16'h0);
    chk("wrap_w0", getword(31), 32'hFFF0);
    chk("wrap_w1", getword(47), 32'h0000);
    chk("wrap_w2", getword(63), 32'h0010);

    xfer(8'hD7, 24'h000000, 32, 1'b0, -1, -1, 12'h0, 16'h0);
    w = getword(7);
    chk("stat_b0", w[15:8], 32'hB4);
    chk("stat_b1", w[7:0], 32'hB4);
    w = getword(23);
    chk("stat_b2", w[15:8], 32'hB4);

    xfer(8'h55, 24'h002402, 56, 1'b0, -1, -1, 12'h0, 16'h0);
    acc = 1'b0;
    for (int i = 0; i < 56; i++) acc = acc | rx[i];
    chk("ignore_zero", acc, 0);
    xfer(8'h03, 24'h002402, 48, 1'b0, -1, -1, 12'h0, 16'h0);
    chk("after_ignore_w0", getword(31), 32'h9010);

    xfer(8'h03, 24'h002402, 52, 1'b0, -1, -1, 12'h0, 16'h0);
    xfer(8'h03, 24'h000000, 48, 1'b0, -1, -1, 12'h0, 16'h0);
    chk("after_abort_w0", getword(31), 32'h0000);

    xfer(8'h03, 24'h002402, 40, 1'b1, -1, -1, 12'h0, 16'h0);
    xfer(8'h03, 24'h000000, 48, 1'b0, -1, -1, 12'h0, 16'h0);
    chk("after_simul_w0", getword(31), 32'h0000);

    xfer(8'h03, 24'h002402, 80, 1'b0, 50, -1, 12'h0, 16'h0);
    xfer(8'h03, 24'h002402, 48, 1'b0, -1, -1, 12'h0, 16'h0);
    chk("after_reset_w0", getword(31), 32'h9010);

    xfer(8'h03, 24'h000000, 60, 1'b0, -1, 40, 12'h005, 16'hDEAD);
    idle_load(12'h006, 16'hBEEF);
    xfer(8'h03, 24'h00000A, 64, 1'b0, -1, -1, 12'h0, 16'h0);
    chk("ld_active_ignored", getword(31), 32'h0050);
    chk("ld_idle_written", getword(47), 32'hBEEF);

    for (int t = 0; t < 12; t++) begin
      idle_load(12'($urandom), 16'($urandom));
      sel = $urandom_range(0, 3);
      case (sel)
        0:       op = 8'h03;
        1:       op = 8'h0B;
        2:       op = 8'hD7;
        default: op = 8'($urandom);
      endcase
      xfer(op, 24'($urandom), $urandom_range(8, 90), ($urandom_range(0, 5) == 0),
           -1, -1, 12'h0, 16'h0);
    end

    wait_clk(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
